// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared store-size enum, buffer entry layout and size decode helper
package store_buffer_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_BYTE,
        ST_HALF_WORD,
        ST_WORD,
        ST_NONE
    } store_size_e;

    typedef struct packed {
        logic [29:0]               word_addr;
        logic [31:0]               data;
        logic [BYTES_PER_WORD-1:0] mask;
    } sb_entry_t;

    // The request port is 3 bits wide; any encoding beyond the enum is treated as no store.
    function automatic store_size_e decode_size(input logic [2:0] raw);
        return raw[2] ? ST_NONE : store_size_e'(raw[1:0]);
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: store request, memory write port, load-forward query and status
interface store_buffer_if;
    import store_buffer_pkg::*;

    logic                      st_valid;
    logic                      st_ready;
    logic [31:0]               st_addr;
    logic [31:0]               st_data;
    logic [2:0]                st_size;
    logic                      st_misaligned;
    logic                      mem_wr_valid;
    logic                      mem_wr_ready;
    logic [31:0]               mem_wr_addr;
    logic [31:0]               mem_wr_data;
    logic [BYTES_PER_WORD-1:0] mem_wr_mask;
    logic                      sb_empty;
    logic [31:0]               ld_addr;
    logic                      ld_hit;
    logic [31:0]               ld_fwd_data;
    logic [BYTES_PER_WORD-1:0] ld_fwd_mask;

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_wr_ready, ld_addr,
        input  st_ready, st_misaligned, mem_wr_valid, mem_wr_addr, mem_wr_data,
               mem_wr_mask, sb_empty, ld_hit, ld_fwd_data, ld_fwd_mask
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_wr_ready, ld_addr,
        output st_ready, st_misaligned, mem_wr_valid, mem_wr_addr, mem_wr_data,
               mem_wr_mask, sb_empty, ld_hit, ld_fwd_data, ld_fwd_mask
    );

endinterface

// File: rtl/store_align.sv
// store_align: byte-lane steering, byte mask and misalignment detect for one store
module store_align
    import store_buffer_pkg::*;
(
    input  logic [1:0]                addr_lo,
    input  store_size_e               size,
    input  logic [31:0]               data_in,
    output logic [BYTES_PER_WORD-1:0] mask,
    output logic [31:0]               data,
    output logic                      misaligned
);

    // Replicate the low bytes across lanes so the mask alone selects the target lane.
    always_comb begin
        mask = size == ST_BYTE      ? 4'b0001 << addr_lo :
               size == ST_HALF_WORD ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
               size == ST_WORD      ? 4'b1111 : 4'b0000;
        data = size == ST_BYTE      ? {4{data_in[7:0]}} :
               size == ST_HALF_WORD ? {2{data_in[15:0]}} : data_in;
        misaligned = (size == ST_HALF_WORD && addr_lo[0]) ||
                     (size == ST_WORD && addr_lo != 2'b00);
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: aligns stores and queues them in a FIFO draining to memory; STORE_FWD_EN adds load forwarding
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input logic          clk,
    input logic          reset,
    store_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]             head;
    logic [PW-1:0]             tail;
    logic [PW:0]               count;
    sb_entry_t                 mem [DEPTH];
    sb_entry_t                 head_entry;
    store_size_e               size;
    logic [BYTES_PER_WORD-1:0] lane_mask;
    logic [XLEN-1:0]           lane_data;
    logic                      misaligned;
    logic                      enq;
    logic                      deq;

    assign size = decode_size(bus.st_size);

    store_align u_align (
        .addr_lo    (bus.st_addr[1:0]),
        .size       (size),
        .data_in    (bus.st_data),
        .mask       (lane_mask),
        .data       (lane_data),
        .misaligned (misaligned)
    );

    // Ready depends only on the occupancy register, so memory backpressure never reaches the pipeline combinationally.
    assign bus.st_ready      = count != (PW+1)'(DEPTH);
    assign bus.st_misaligned = bus.st_valid & misaligned;
    assign enq               = bus.st_valid & bus.st_ready & ~misaligned & (size != ST_NONE);
    assign deq               = bus.mem_wr_valid & bus.mem_wr_ready;
    assign bus.mem_wr_valid  = count != '0;
    assign bus.sb_empty      = count == '0;
    assign head_entry        = mem[head];
    assign bus.mem_wr_addr   = bus.sb_empty ? '0 : {head_entry.word_addr, 2'b00};
    assign bus.mem_wr_data   = bus.sb_empty ? '0 : head_entry.data;
    assign bus.mem_wr_mask   = bus.sb_empty ? '0 : head_entry.mask;

    // Pointers and occupancy; reset discards every pending entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            count <= count + (PW+1)'(enq) - (PW+1)'(deq);
        end
    end

    // Entry storage is not reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (enq) mem[tail] <= '{word_addr: bus.st_addr[31:2], data: lane_data, mask: lane_mask};
    end

`ifdef STORE_FWD_EN
    // Scan oldest to youngest so the youngest matching entry overrides older ones.
    always_comb begin
        bus.ld_hit      = 1'b0;
        bus.ld_fwd_data = '0;
        bus.ld_fwd_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PW+1)'(i) < count && mem[head + PW'(i)].word_addr == bus.ld_addr[31:2]) begin
                bus.ld_hit      = 1'b1;
                bus.ld_fwd_data = mem[head + PW'(i)].data;
                bus.ld_fwd_mask = mem[head + PW'(i)].mask;
            end
        end
    end
`else
    assign bus.ld_hit      = 1'b0;
    assign bus.ld_fwd_data = '0;
    assign bus.ld_fwd_mask = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed vector table plus corner-case sequences for store_buffer
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    store_buffer_if bus ();

    store_buffer #(.DEPTH(4), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  size;
        logic        mis;
        logic        enq;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] size);
        bus.st_valid = 1'b1;
        bus.st_addr  = addr;
        bus.st_data  = data;
        bus.st_size  = size;
        tick();
        bus.st_valid = 1'b0;
    endtask

    initial begin
        // size codes: 0 byte, 1 half, 2 word, 3 none
        vecs[0] = '{32'h0000_0100, 32'hDEAD_BEEF, 3'd2, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0203, 32'h0000_00AB, 3'd0, 1'b0, 1'b1, 4'b1000, 32'hABAB_ABAB};
        vecs[2] = '{32'h0000_0202, 32'h0000_1234, 3'd1, 1'b0, 1'b1, 4'b1100, 32'h1234_1234};
        vecs[3] = '{32'h0000_0200, 32'hCAFE_5678, 3'd1, 1'b0, 1'b1, 4'b0011, 32'h5678_5678};
        vecs[4] = '{32'h0000_0001, 32'h1234_5677, 3'd0, 1'b0, 1'b1, 4'b0010, 32'h7777_7777};
        vecs[5] = '{32'h0000_0101, 32'h1111_1111, 3'd2, 1'b1, 1'b0, 4'b0000, 32'h0};
        vecs[6] = '{32'h0000_0103, 32'h0000_2222, 3'd1, 1'b1, 1'b0, 4'b0000, 32'h0};
        vecs[7] = '{32'h0000_0104, 32'h3333_3333, 3'd3, 1'b0, 1'b0, 4'b0000, 32'h0};
        vecs[8] = '{32'h0000_0102, 32'h4444_4444, 3'd2, 1'b1, 1'b0, 4'b0000, 32'h0};
        vecs[9] = '{32'hFFFF_FFFE, 32'h0000_005A, 3'd0, 1'b0, 1'b1, 4'b0100, 32'h5A5A_5A5A};

        reset = 1'b1;
        bus.st_valid = 1'b0;
        bus.st_addr = '0;
        bus.st_data = '0;
        bus.st_size = 3'd3;
        bus.mem_wr_ready = 1'b0;
        bus.ld_addr = '0;
        tick();
        tick();
        check("rst_wr_valid", bus.mem_wr_valid, 0);
        check("rst_empty", bus.sb_empty, 1);
        check("rst_ready", bus.st_ready, 1);
        check("rst_ld_hit", bus.ld_hit, 0);
        check("rst_wr_addr", bus.mem_wr_addr, 0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 10; k++) begin
            bus.st_valid = 1'b1;
            bus.st_addr  = vecs[k].addr;
            bus.st_data  = vecs[k].data;
            bus.st_size  = vecs[k].size;
            #1;
            check($sformatf("v%0d_misaligned", k), bus.st_misaligned, vecs[k].mis);
            @(posedge clk);
            #1;
            bus.st_valid = 1'b0;
            #1;
            check($sformatf("v%0d_empty", k), bus.sb_empty, !vecs[k].enq);
            if (vecs[k].enq) begin
                check($sformatf("v%0d_addr", k), bus.mem_wr_addr, {vecs[k].addr[31:2], 2'b00});
                check($sformatf("v%0d_data", k), bus.mem_wr_data, vecs[k].wdata);
                check($sformatf("v%0d_mask", k), bus.mem_wr_mask, vecs[k].mask);
            end
            bus.mem_wr_ready = 1'b1;
            tick();
            bus.mem_wr_ready = 1'b0;
            #1;
            check($sformatf("v%0d_drained", k), bus.sb_empty, 1);
            check($sformatf("v%0d_idle_data", k), bus.mem_wr_data, 0);
        end

        bus.st_addr = 32'h101;
        bus.st_size = 3'd2;
        #1;
        check("mis_without_valid", bus.st_misaligned, 0);

        // fill to full under backpressure; fifth store must be refused
        for (int k = 0; k < 5; k++) begin
            bus.st_valid = 1'b1;
            bus.st_addr  = 32'h400 + 4 * k;
            bus.st_data  = 32'hA000_0000 + k;
            bus.st_size  = 3'd2;
            #1;
            check($sformatf("full_ready%0d", k), bus.st_ready, k < 4);
            tick();
        end
        bus.st_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("stall_addr%0d", s), bus.mem_wr_addr, 32'h400);
            check($sformatf("stall_data%0d", s), bus.mem_wr_data, 32'hA000_0000);
            tick();
        end
        bus.mem_wr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_addr%0d", k), bus.mem_wr_addr, 32'h400 + 4 * k);
            check($sformatf("drain_data%0d", k), bus.mem_wr_data, 32'hA000_0000 + k);
            tick();
        end
        check("drain_empty", bus.sb_empty, 1);
        bus.mem_wr_ready = 1'b0;

        // full: enqueue blocked even while a dequeue happens
        for (int k = 0; k < 4; k++) push(32'h500 + 4 * k, 32'hB0 + k, 3'd2);
        bus.st_valid = 1'b1;
        bus.st_addr = 32'h510;
        bus.st_data = 32'hB4;
        bus.mem_wr_ready = 1'b1;
        #1;
        check("full_deq_ready", bus.st_ready, 0);
        tick();
        bus.st_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            check($sformatf("full_deq_data%0d", k), bus.mem_wr_data, 32'hB0 + k);
            tick();
        end
        check("full_deq_empty", bus.mem_wr_valid, 0);
        bus.mem_wr_ready = 1'b0;

        // simultaneous enqueue and dequeue at count 2
        push(32'h600, 32'hC0, 3'd2);
        push(32'h604, 32'hC1, 3'd2);
        bus.st_valid = 1'b1;
        bus.st_addr = 32'h608;
        bus.st_data = 32'hC2;
        bus.mem_wr_ready = 1'b1;
        tick();
        bus.st_valid = 1'b0;
        check("simul_head1", bus.mem_wr_data, 32'hC1);
        tick();
        check("simul_valid2", bus.mem_wr_valid, 1);
        check("simul_head2", bus.mem_wr_data, 32'hC2);
        tick();
        check("simul_empty", bus.sb_empty, 1);
        bus.mem_wr_ready = 1'b0;

        // asynchronous reset mid-drain
        for (int k = 0; k < 3; k++) push(32'h700 + 4 * k, 32'hD0 + k, 3'd2);
        check("pre_reset_valid", bus.mem_wr_valid, 1);
        reset = 1'b1;
        #1;
        check("async_rst_valid", bus.mem_wr_valid, 0);
        check("async_rst_empty", bus.sb_empty, 1);
        tick();
        reset = 1'b0;
        bus.mem_wr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("post_rst_valid%0d", k), bus.mem_wr_valid, 0);
        end
        bus.mem_wr_ready = 1'b0;

        // load forwarding: youngest matching entry wins
        push(32'h300, 32'h1111_1111, 3'd2);
        push(32'h301, 32'h0000_0022, 3'd0);
        bus.ld_addr = 32'h300;
        #1;
`ifdef STORE_FWD_EN
        check("fwd_hit", bus.ld_hit, 1);
        check("fwd_mask", bus.ld_fwd_mask, 4'b0010);
        check("fwd_data", bus.ld_fwd_data, 32'h2222_2222);
        bus.ld_addr = 32'h304;
        #1;
        check("fwd_miss", bus.ld_hit, 0);
`else
        check("fwd_off_hit", bus.ld_hit, 0);
        check("fwd_off_mask", bus.ld_fwd_mask, 0);
        check("fwd_off_data", bus.ld_fwd_data, 0);
`endif
        bus.mem_wr_ready = 1'b1;
        check("order_mask0", bus.mem_wr_mask, 4'b1111);
        tick();
        check("order_mask1", bus.mem_wr_mask, 4'b0010);
        check("order_addr1", bus.mem_wr_addr, 32'h300);
        tick();
        check("order_empty", bus.sb_empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-side counterpart to the load truncation path.
- Accepts store requests from the MEM stage: byte address, raw rs2 data and store size.
- Steers the data onto the correct byte lanes and generates a 4-bit byte mask.
- Queues the result in a small FIFO and drains it to data memory over a valid/ready write port, decoupling pipeline stores from memory write stalls.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of two, at least 2.
- XLEN, 32, address and data width; fixed at 32 in this revision.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- st_valid  in  1  store request present.
- st_ready  out  1  buffer can accept a store.
- st_addr  in  32  byte address.
- st_data  in  32  unaligned store data (rs2).
- st_size  in  3  storeSize enum (BYTE, HALF_WORD, WORD, NONE).
- st_misaligned  out  1  current request is misaligned.
- mem_wr_valid  out  1  head entry is presented to memory.
- mem_wr_ready  in  1  memory accepts the write.
- mem_wr_addr  out  32  word address; bits [1:0] are always 0.
- mem_wr_data  out  32  lane-aligned data.
- mem_wr_mask  out  4  byte enables.
- sb_empty  out  1  no pending entries; used for fence and drain.
- ld_addr  in  32  load query address (STORE_FWD_EN only).
- ld_hit  out  1  forwarding hit.
- ld_fwd_data  out  32  forwarded data.
- ld_fwd_mask  out  4  forwarded byte lanes.

Behaviour:
- Reset (asynchronous, active-high):
  - head, tail and count go to 0.
  - mem_wr_valid=0, sb_empty=1, ld_hit=0.
  - Entry storage is not reset.
  - Reset during any operation discards all pending entries; nothing is written afterwards.
- Alignment and mask, combinational in store_align:
  - BYTE: mask = 1 << addr[1:0]; data = {4{st_data[7:0]}}.
  - HALF_WORD: mask = 0011 when addr[1]=0, 1100 when addr[1]=1; data = {2{st_data[15:0]}}.
  - WORD: mask = 1111; data = st_data.
  - NONE: mask = 0000.
- Misalignment:
  - HALF_WORD with addr[0]=1 is misaligned.
  - WORD with addr[1:0]≠0 is misaligned.
  - st_misaligned = st_valid & misaligned. It is combinational and independent of st_ready.
- st_ready = (count != DEPTH). It depends only on registered state, so there is no combinational path from mem_wr_ready.
- Enqueue: st_valid & st_ready & ~misaligned & (st_size != NONE).
  - Entry {addr[31:2], data, mask} is written at tail; tail increments.
  - Misaligned and NONE requests are dropped silently and still count as handshaken.
- Dequeue: mem_wr_valid & mem_wr_ready; head increments.
- mem_wr_valid = (count != 0).
  - mem_wr_addr, mem_wr_data and mem_wr_mask come from the head entry, and are forced to 0 when the buffer is empty.
  - Outputs are held stable while valid is high and ready is low.
- Latency: an enqueued store appears on mem_wr_* at the earliest on the cycle after acceptance. There is no bypass.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. When full, enqueue is blocked that cycle even if a dequeue occurs.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- sb_empty = (count == 0).
- Ordering: strict FIFO; there is no write merging.

Optional Feature:
- Macro: STORE_FWD_EN.
- Defined:
  - Every valid entry whose word address matches ld_addr[31:2] is scanned.
  - The youngest match supplies ld_fwd_data and ld_fwd_mask; ld_hit=1.
  - The result is combinational.
  - Older partially overlapping entries are not merged. The core must stall on a partial hit, i.e. ld_fwd_mask does not cover the load.
- Undefined: ld_hit, ld_fwd_data and ld_fwd_mask are tied to 0, and ld_addr is unused.

Decomposition:
- Add to the shared HighLevelControl package:
  - typedef enum logic[1:0] storeSize {BYTE, HALF_WORD, WORD, NONE}. It is package-scoped, so each enum's literals must be unique; prefix them (ST_BYTE, ...) if they clash with truncSrc.
  - localparam BYTES_PER_WORD = 4.
- One sub-module: store_align (combinational: addr[1:0], size → mask, lane data, misaligned).
- FIFO storage and pointers live in store_buffer.

Test Plan:
- Single store, mem_wr_ready=1: SW addr 0x100, data 0xDEADBEEF → one cycle later mem_wr_addr=0x100, data=0xDEADBEEF, mask=1111. sb_empty returns to 1 after the handshake.
- Byte and half lanes: SB addr 0x203, data 0x000000AB → mask=1000, data=0xABABABAB. SH addr 0x202, data 0x1234 → mask=1100, data=0x12341234.
- Misaligned: SW addr 0x101 → st_misaligned=1, no entry enqueued, sb_empty stays 1. SH addr 0x103 → st_misaligned=1.
- Backpressure and full: mem_wr_ready=0, 5 consecutive SW stores with DEPTH=4 → st_ready=0 after the 4th store. Releasing ready drains 4 writes in order with outputs stable while stalled. Simultaneous enqueue and dequeue at count=2 keeps count=2.
- Reset mid-drain: 3 entries pending, assert reset for 1 cycle → mem_wr_valid drops immediately (asynchronous), sb_empty=1, and no stale writes appear after release.
- STORE_FWD_EN: SW 0x300=0x11111111, then SB 0x301=0x22, ld_addr=0x300 → ld_hit=1, mask=0010, data lane 1=0x22 (youngest wins). With the macro off → ld_hit=0.
